// File: rtl/key_scan.sv
// key_scan: two-key synchronise/debounce front end with press,
// long-press and auto-repeat events driving an 8-bit up/down value.
module key_scan #(
   parameter logic [31:0] DEBOUNCE_CNT = 32'd491520,
   parameter logic [31:0] LONG_CNT     = 32'd49152000,
   parameter logic [31:0] REPEAT_CNT   = 32'd4915200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key1_n,
   input  logic       key2_n,
   output logic       key1_press,
   output logic       key2_press,
   output logic       key1_long,
   output logic       key2_long,
   output logic [1:0] key_state,
   output logic [7:0] count
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      HELD,
      LONG_HELD,
      RELEASE_DB
   } state_t;

   logic [1:0] raw_n;
   logic [1:0] press;
   logic [1:0] long_ev;
   logic [1:0] held;

   assign raw_n = {key2_n, key1_n};

   for (genvar k = 0; k < 2; k++) begin : g_key
      logic        sync1;
      logic        sync2;
      state_t      state;
      state_t      state_nxt;
      logic [31:0] timer;
      logic [31:0] timer_nxt;
      logic        from_long;
      logic        from_long_nxt;
      logic        press_q;
      logic        press_nxt;
      logic        long_q;
      logic        long_nxt;
      logic        held_q;
      logic        held_nxt;

      always_ff @(posedge clk) begin
         if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state     <= IDLE;
            timer     <= '0;
            from_long <= 1'b0;
            press_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
         end else begin
            sync1     <= raw_n[k];
            sync2     <= sync1;
            state     <= state_nxt;
            timer     <= timer_nxt;
            from_long <= from_long_nxt;
            press_q   <= press_nxt;
            long_q    <= long_nxt;
            held_q    <= held_nxt;
         end
      end

      // sync2 high means released; every transition clears the timer
      always_comb begin
         state_nxt     = state;
         timer_nxt     = timer + 32'd1;
         from_long_nxt = from_long;
         press_nxt     = 1'b0;
         long_nxt      = 1'b0;
         unique case (state)
            IDLE: begin
               timer_nxt = '0;
               if (!sync2)
                  state_nxt = PRESS_DB;
            end
            PRESS_DB: begin
               if (sync2) begin
                  state_nxt = IDLE;
                  timer_nxt = '0;
               end else if (timer == DEBOUNCE_CNT - 32'd1) begin
                  state_nxt = HELD;
                  timer_nxt = '0;
                  press_nxt = 1'b1;
               end
            end
            HELD: begin
               if (sync2) begin
                  state_nxt     = RELEASE_DB;
                  timer_nxt     = '0;
                  from_long_nxt = 1'b0;
               end else if (timer == LONG_CNT - 32'd1) begin
                  state_nxt = LONG_HELD;
                  timer_nxt = '0;
                  long_nxt  = 1'b1;
               end
            end
            LONG_HELD: begin
               if (sync2) begin
                  state_nxt     = RELEASE_DB;
                  timer_nxt     = '0;
                  from_long_nxt = 1'b1;
               end else if (timer == REPEAT_CNT - 32'd1) begin
                  timer_nxt = '0;
                  press_nxt = 1'b1;
               end
            end
            RELEASE_DB: begin
               if (!sync2) begin
                  state_nxt = from_long ? LONG_HELD : HELD;
                  timer_nxt = '0;
               end else if (timer == DEBOUNCE_CNT - 32'd1) begin
                  state_nxt = IDLE;
                  timer_nxt = '0;
               end
            end
            default: begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end
         endcase
         held_nxt = (state_nxt == HELD) ||
                    (state_nxt == LONG_HELD) ||
                    (state_nxt == RELEASE_DB);
      end

      assign press[k]   = press_q;
      assign long_ev[k] = long_q;
      assign held[k]    = held_q;
   end

   // simultaneous key1/key2 events cancel
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 8'd0;
      end else begin
         case (press)
            2'b01:   count <= count + 8'd1;
            2'b10:   count <= count - 8'd1;
            default: count <= count;
         endcase
      end
   end

   assign key1_press = press[0];
   assign key2_press = press[1];
   assign key1_long  = long_ev[0];
   assign key2_long  = long_ev[1];
   assign key_state  = held;

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: directed vector table plus a reset-while-held sequence
// for key_scan with short debounce/long/repeat counts.
module tb_key_scan;

   logic       clk;
   logic       reset;
   logic       key1_n;
   logic       key2_n;
   logic       key1_press;
   logic       key2_press;
   logic       key1_long;
   logic       key2_long;
   logic [1:0] key_state;
   logic [7:0] count;

   int tests;
   int fails;

   typedef struct {
      logic       rst;
      logic       k1n;
      logic       k2n;
      logic [3:0] ev;
      logic [1:0] ks;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[$];

   key_scan #(
      .DEBOUNCE_CNT(32'd4),
      .LONG_CNT    (32'd20),
      .REPEAT_CNT  (32'd5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .key1_n    (key1_n),
      .key2_n    (key2_n),
      .key1_press(key1_press),
      .key2_press(key2_press),
      .key1_long (key1_long),
      .key2_long (key2_long),
      .key_state (key_state),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ev = {key1_press, key2_press, key1_long, key2_long}
   function automatic void add(int n, logic r, logic a, logic b,
                               logic [3:0] ev, logic [1:0] ks,
                               logic [7:0] c);
      vec_t v;
      v.rst = r;
      v.k1n = a;
      v.k2n = b;
      v.ev  = ev;
      v.ks  = ks;
      v.cnt = c;
      for (int i = 0; i < n; i++)
         tbl.push_back(v);
   endfunction

   task automatic step(input string nm, input int idx, input vec_t v);
      logic [13:0] got;
      logic [13:0] exp;
      reset  = v.rst;
      key1_n = v.k1n;
      key2_n = v.k2n;
      @(posedge clk);
      #1;
      got = {key1_press, key2_press, key1_long, key2_long,
             key_state, count};
      exp = {v.ev, v.ks, v.cnt};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got ev=%b ks=%b cnt=%0d, expected ev=%b ks=%b cnt=%0d",
                  nm, idx, got[13:10], got[9:8], got[7:0],
                  exp[13:10], exp[9:8], exp[7:0]);
      end
   endtask

   initial begin
      vec_t v;
      tests  = 0;
      fails  = 0;
      reset  = 1'b1;
      key1_n = 1'b1;
      key2_n = 1'b1;

      // reset, clean key1 press and release
      add(2,  1, 1, 1, 4'b0000, 2'b00, 8'd0);
      add(6,  0, 0, 1, 4'b0000, 2'b00, 8'd0);
      add(1,  0, 0, 1, 4'b1000, 2'b01, 8'd0);
      add(1,  0, 0, 1, 4'b0000, 2'b01, 8'd1);
      add(6,  0, 1, 1, 4'b0000, 2'b01, 8'd1);
      add(2,  0, 1, 1, 4'b0000, 2'b00, 8'd1);
      // bounce: 3 low, 1 high, then steady low
      add(3,  0, 0, 1, 4'b0000, 2'b00, 8'd1);
      add(1,  0, 1, 1, 4'b0000, 2'b00, 8'd1);
      add(6,  0, 0, 1, 4'b0000, 2'b00, 8'd1);
      add(1,  0, 0, 1, 4'b1000, 2'b01, 8'd1);
      add(1,  0, 0, 1, 4'b0000, 2'b01, 8'd2);
      // release glitch in HELD, long timer restarts
      add(2,  0, 1, 1, 4'b0000, 2'b01, 8'd2);
      add(22, 0, 0, 1, 4'b0000, 2'b01, 8'd2);
      add(1,  0, 0, 1, 4'b0010, 2'b01, 8'd2);
      add(6,  0, 1, 1, 4'b0000, 2'b01, 8'd2);
      add(2,  0, 1, 1, 4'b0000, 2'b00, 8'd2);
      // both keys together: events pair up, count holds
      add(6,  0, 0, 0, 4'b0000, 2'b00, 8'd2);
      add(1,  0, 0, 0, 4'b1100, 2'b11, 8'd2);
      add(19, 0, 0, 0, 4'b0000, 2'b11, 8'd2);
      add(1,  0, 0, 0, 4'b0011, 2'b11, 8'd2);
      add(4,  0, 0, 0, 4'b0000, 2'b11, 8'd2);
      add(1,  0, 0, 0, 4'b1100, 2'b11, 8'd2);
      add(2,  0, 0, 0, 4'b0000, 2'b11, 8'd2);
      // reset while both held, then key2 long press and repeat
      add(1,  1, 1, 1, 4'b0000, 2'b00, 8'd0);
      add(6,  0, 1, 0, 4'b0000, 2'b00, 8'd0);
      add(1,  0, 1, 0, 4'b0100, 2'b10, 8'd0);
      add(19, 0, 1, 0, 4'b0000, 2'b10, 8'd255);
      add(1,  0, 1, 0, 4'b0001, 2'b10, 8'd255);
      add(4,  0, 1, 0, 4'b0000, 2'b10, 8'd255);
      add(1,  0, 1, 0, 4'b0100, 2'b10, 8'd255);
      add(4,  0, 1, 0, 4'b0000, 2'b10, 8'd254);
      add(1,  0, 1, 0, 4'b0100, 2'b10, 8'd254);
      add(4,  0, 1, 0, 4'b0000, 2'b10, 8'd253);
      add(1,  0, 1, 0, 4'b0100, 2'b10, 8'd253);
      add(1,  0, 1, 0, 4'b0000, 2'b10, 8'd252);

      for (int i = 0; i < tbl.size(); i++)
         step("vec", i, tbl[i]);

      // reset in LONG_HELD with key2 still low: no exit pulse,
      // key re-debounces from idle
      v.k1n = 1'b1;
      v.k2n = 1'b0;
      v.ev  = 4'b0000;
      v.ks  = 2'b00;
      v.cnt = 8'd0;
      v.rst = 1'b1;
      for (int i = 0; i < 2; i++)
         step("rst_hold", i, v);
      v.rst = 1'b0;
      for (int i = 2; i < 8; i++)
         step("rst_hold", i, v);
      v.ev = 4'b0100;
      v.ks = 2'b10;
      step("rst_hold", 8, v);
      v.ev  = 4'b0000;
      v.cnt = 8'd255;
      step("rst_hold", 9, v);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/key_scan.md
# key_scan

Debounced two-key front-panel input block: the input-side counterpart to the LED blinker/counter driver.
- Synchronises two raw active-low pushbuttons on the 49.152 MHz system clock and debounces each independently.
- Emits single-cycle press, long-press and auto-repeat events.
- Maintains an 8-bit up/down value driven by the keys, for the display/LED path to consume.

## Interface
Parameters:
- DEBOUNCE_CNT, 32'd491520, consecutive stable cycles required to accept a level change (10 ms).
- LONG_CNT, 32'd49152000, cycles a key must stay accepted-pressed before a long-press event (1 s).
- REPEAT_CNT, 32'd4915200, auto-repeat period after long press (100 ms, 10 Hz).

Ports:
- clk  input  1  system clock, 49.152 MHz.
- reset  input  1  synchronous, active-high reset.
- key1_n  input  1  raw button 1, low = pressed, asynchronous to clk.
- key2_n  input  1  raw button 2, low = pressed.
- key1_press  output  1  one-cycle pulse on accepted press or auto-repeat of key 1.
- key2_press  output  1  same for key 2.
- key1_long  output  1  one-cycle pulse when key 1 reaches long-press.
- key2_long  output  1  same for key 2.
- key_state  output  2  debounced level, bit0 = key1, bit1 = key2, 1 = pressed.
- count  output  8  up/down value: +1 per key1_press, -1 per key2_press.

## Operation
- Each raw input passes through a two-flop synchroniser. Each flop resets to 1 (released).
- One FSM per key, with states IDLE, PRESS_DB, HELD, LONG_HELD, RELEASE_DB. Each FSM has a 32-bit timer, cleared on every state entry.
- IDLE: on a synchronised low sample, go to PRESS_DB.
- PRESS_DB:
  - A high sample returns to IDLE (bounce rejected).
  - Otherwise the timer increments. A low sample with timer == DEBOUNCE_CNT-1 goes to HELD and registers a press pulse.
- HELD:
  - A high sample goes to RELEASE_DB.
  - Otherwise the timer increments. A low sample with timer == LONG_CNT-1 goes to LONG_HELD and registers a long pulse.
- LONG_HELD:
  - A high sample goes to RELEASE_DB.
  - Otherwise the timer increments. At timer == REPEAT_CNT-1 it emits a press pulse and clears the timer.
- RELEASE_DB:
  - Remembers its origin (HELD or LONG_HELD) in a flag.
  - A low sample returns to the origin state with the timer cleared and no pulse.
  - A high sample with timer == DEBOUNCE_CNT-1 goes to IDLE.
- key_state bit is 1 in HELD, LONG_HELD and RELEASE_DB, and 0 in IDLE and PRESS_DB.
- count:
  - Key1 press only: count+1, wrapping 255→0.
  - Key2 press only: count-1, wrapping 0→255.
  - Both press pulses in the same cycle: count unchanged.
- The two keys are fully independent. Simultaneous holds each produce their own long and repeat events.

## Timing
- All outputs are registered. Reset values:
  - key1_press, key2_press, key1_long, key2_long = 0.
  - key_state = 2'b00.
  - count = 8'd0.
- Reset also sets FSMs to IDLE, timers to 0, and synchronisers to 1.
- Reset asserted mid-operation:
  - All outputs and state return to their reset values on that edge.
  - No event pulse is generated on reset exit, even if the key is still held. The key re-debounces from IDLE.
- Press latency: the raw level is low from before edge E. The press pulse is high in the cycle following edge E+2+DEBOUNCE_CNT, and key_state rises at that same edge.
- Long pulse: LONG_CNT edges after the HELD-entry edge.
- Repeat pulses: every REPEAT_CNT edges after the LONG_HELD-entry edge.
- count updates on the edge after the press pulse is high, i.e. count lags the pulse by one cycle.
- Release: key_state falls DEBOUNCE_CNT+2 edges after the raw input goes high and stays high.
- Pulses never exceed one cycle. The long pulse and a repeat press pulse never coincide.

## Test plan
All tests use DEBOUNCE_CNT=4, LONG_CNT=20, REPEAT_CNT=5.
- Clean press: key1_n low before edge 1 → key1_press high only in the cycle after edge 7; key_state=01 from edge 7; count=1 after edge 8.
- Bounce rejection: key1_n low for 3 cycles, high 1 cycle, then low steady → no pulse during the glitch; exactly one key1_press, 6 edges after the final low sample begins.
- Long press and repeat: hold key2_n low from count=0 → key2_press; key2_long 20 edges later; repeats every 5 edges; count steps 255, 254, 253...
- Release glitch: key held in HELD, key high for 2 cycles then low → no IDLE, no new press pulse, key_state stays 1; the hold timer restarts from 0.
- Simultaneous: both keys pressed on the same edge, count=10 → both press pulses in the same cycle, count stays 10, key_state=11.
- Reset mid-hold: assert reset in LONG_HELD with count=37 → all outputs 0 next cycle; after deassert with the key still low, press fires DEBOUNCE_CNT+2 edges later and count becomes 1.
